// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed digit display controller.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  localparam int BCD_W = 4;
  localparam int SEG_W = 8;
  localparam logic [SEG_W-1:0] SEG_OFF = 8'h00;
  localparam int DP_BIT = 0;

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Display-side bundle: stopwatch digits in, shared decoder loop, segment/anode pins out.
interface digit_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  import disp_pkg::*;

  logic                        enable;
  logic [BCD_W*NUM_DIGITS-1:0] digits_i;
  logic [NUM_DIGITS-1:0]       dp_i;
  logic [BCD_W-1:0]            bcd_o;
  logic [SEG_W-1:0]            seg_i;
  logic [SEG_W-1:0]            seg_o;
  logic [NUM_DIGITS-1:0]       an_o;
  logic                        frame_o;

  modport master (
    output enable, digits_i, dp_i, seg_i,
    input  bcd_o, seg_o, an_o, frame_o
  );

  modport slave (
    input  enable, digits_i, dp_i, seg_i,
    output bcd_o, seg_o, an_o, frame_o
  );

endinterface

// File: rtl/digit_scan_ctrl_slot_timer.sv
// Per-digit slot counter: runs 0..PRESCALE-1 and flags the end of dead time and of the slot.
module slot_timer #(
  parameter int PRESCALE    = 10000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic dead_done,
  output logic slot_end
);
  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 2;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || slot_end) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign dead_done = (count == CW'(DEAD_CYCLES - 1));
  assign slot_end  = (count == CW'(PRESCALE - 1));

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexes NUM_DIGITS BCD digits onto one shared decoder and segment bus with dead-time blanking.
// Optional feature: define LEADING_ZERO_BLANK_EN to keep leading-zero digits dark.
module digit_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int PRESCALE    = 10000,
  parameter int DEAD_CYCLES = 16
) (
  input logic              clk,
  input logic              rst_n,
  digit_scan_ctrl_if.slave bus
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] digit_vec_t;

  state_t                state, state_next;
  logic [IW-1:0]         idx, idx_next;
  digit_vec_t            snap, snap_next, digits_in;
  logic [NUM_DIGITS-1:0] dp_snap, dp_snap_next;
  logic [NUM_DIGITS-1:0] mask, mask_next, new_mask;
  logic [BCD_W-1:0]      bcd_q, bcd_next;
  logic [SEG_W-1:0]      seg_q, seg_next;
  logic [NUM_DIGITS-1:0] an_q, an_next;
  logic                  frame_q, frame_next;
  logic                  timer_clear, dead_done, slot_end;

  assign digits_in   = bus.digits_i;
  // Holding the timer clear through IDLE makes the first slot start at count 0.
  assign timer_clear = !bus.enable || (state == IDLE);

  slot_timer #(
    .PRESCALE   (PRESCALE),
    .DEAD_CYCLES(DEAD_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (timer_clear),
    .dead_done(dead_done),
    .slot_end (slot_end)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Digit k is dark while it and everything above it is zero and it has no decimal point.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    new_mask   = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above  = zero_above && (digits_in[k] == '0);
      new_mask[k] = zero_above && !bus.dp_i[k];
    end
  end
`else
  assign new_mask = '0;
`endif

  always_comb begin
    state_next   = state;
    idx_next     = idx;
    snap_next    = snap;
    dp_snap_next = dp_snap;
    mask_next    = mask;
    bcd_next     = bcd_q;
    seg_next     = seg_q;
    an_next      = an_q;
    frame_next   = 1'b0;
    if (!bus.enable) begin
      state_next = IDLE;
      idx_next   = '0;
      an_next    = '1;
      seg_next   = SEG_OFF;
    end else begin
      unique case (state)
        IDLE: begin
          state_next   = BLANK;
          idx_next     = '0;
          snap_next    = digits_in;
          dp_snap_next = bus.dp_i;
          mask_next    = new_mask;
          bcd_next     = digits_in[0];
          an_next      = '1;
          seg_next     = SEG_OFF;
          frame_next   = 1'b1;
        end
        BLANK: begin
          if (dead_done) begin
            state_next = DRIVE;
            if (!mask[idx]) begin
              seg_next         = bus.seg_i;
              seg_next[DP_BIT] = bus.seg_i[DP_BIT] | dp_snap[idx];
              an_next          = ~(NUM_DIGITS'(1) << idx);
            end
          end
        end
        DRIVE: begin
          if (slot_end) begin
            state_next = BLANK;
            an_next    = '1;
            seg_next   = SEG_OFF;
            if (idx == LAST_IDX) begin
              idx_next     = '0;
              snap_next    = digits_in;
              dp_snap_next = bus.dp_i;
              mask_next    = new_mask;
              bcd_next     = digits_in[0];
              frame_next   = 1'b1;
            end else begin
              idx_next = idx + 1'b1;
              bcd_next = snap[idx + 1'b1];
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BLANK;
      idx     <= '0;
      snap    <= '0;
      dp_snap <= '0;
      mask    <= '0;
      bcd_q   <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= '1;
      frame_q <= 1'b0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      snap    <= snap_next;
      dp_snap <= dp_snap_next;
      mask    <= mask_next;
      bcd_q   <= bcd_next;
      seg_q   <= seg_next;
      an_q    <= an_next;
      frame_q <= frame_next;
    end
  end

  assign bus.bcd_o   = bcd_q;
  assign bus.seg_o   = seg_q;
  assign bus.an_o    = an_q;
  assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl with a real 7-segment decoder in the loop.
// Honours LEADING_ZERO_BLANK_EN in both the reference model and a dedicated sequence.
module tb_digit_scan_ctrl;
  localparam int ND    = 4;
  localparam int PS    = 8;
  localparam int DC    = 2;
  localparam int FRAME = ND * PS;

  typedef struct {
    string      name;
    logic [15:0] digits;
    logic [3:0]  dp;
    int          idx;
    logic [3:0]  exp_an;
    logic [7:0]  exp_seg;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total_cnt;
  int   bad_cnt;

  digit_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  digit_scan_ctrl #(
    .NUM_DIGITS (ND),
    .PRESCALE   (PS),
    .DEAD_CYCLES(DC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [7:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 8'hFC;
      4'd1:    seg_decode = 8'h60;
      4'd2:    seg_decode = 8'hDA;
      4'd3:    seg_decode = 8'hF2;
      4'd4:    seg_decode = 8'h66;
      4'd5:    seg_decode = 8'hB6;
      4'd6:    seg_decode = 8'hBE;
      4'd7:    seg_decode = 8'hE0;
      4'd8:    seg_decode = 8'hFE;
      4'd9:    seg_decode = 8'hF6;
      default: seg_decode = 8'h00;
    endcase
  endfunction

  assign bus.seg_i = seg_decode(bus.bcd_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the display is a pure function of time since the last snapshot.
  int         m_t;
  bit         m_run;
  logic [15:0] m_snap;
  logic [3:0]  m_dp;
  logic [3:0]  m_mask;
  logic [3:0]  exp_an;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_bcd;
  logic        exp_frame;

  function automatic logic [3:0] lz_mask(input logic [15:0] d, input logic [3:0] p);
    lz_mask = '0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int k = 1; k < ND; k++)
      if ((d >> (4 * k)) == 16'd0 && !p[k]) lz_mask[k] = 1'b1;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int   slot;
    int   pos;
    logic [3:0] dig;
    if (!rst_n) begin
      m_run = 1'b1; m_t = 0; m_snap = '0; m_dp = '0; m_mask = '0; exp_frame = 1'b0;
    end else if (!bus.enable) begin
      m_run = 1'b0; exp_frame = 1'b0;
    end else begin
      exp_frame = 1'b0;
      if (!m_run) m_t = 0;
      else        m_t = (m_t + 1) % FRAME;
      if (!m_run || m_t == 0) begin
        m_snap = bus.digits_i; m_dp = bus.dp_i; m_mask = lz_mask(bus.digits_i, bus.dp_i);
        exp_frame = 1'b1;
      end
      m_run = 1'b1;
    end
    slot    = m_t / PS;
    pos     = m_t % PS;
    dig     = 4'((m_snap >> (4 * slot)) & 16'hF);
    exp_bcd = dig;
    exp_an  = 4'hF;
    exp_seg = 8'h00;
    if (m_run && pos >= DC && !m_mask[slot]) begin
      exp_an  = ~(4'b0001 << slot);
      exp_seg = seg_decode(dig) | {7'b0, m_dp[slot]};
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("mdl_an", bus.an_o, exp_an);
      checkOutput("mdl_seg", bus.seg_o, exp_seg);
      checkOutput("mdl_frame", bus.frame_o, exp_frame);
      if (m_run) checkOutput("mdl_bcd", bus.bcd_o, exp_bcd);
      checkOutput("an_onehot", ($countones(~bus.an_o) <= 1), 1);
    end
  end

  vec_t vecs [9];
  logic [3:0] an_exp_tab [4];
  logic [7:0] seg_1234 [4];

  task automatic applyStimulus(input vec_t v);
    bus.enable = 1'b0;
    @(negedge clk);
    bus.digits_i = v.digits;
    bus.dp_i     = v.dp;
    bus.enable   = 1'b1;
    @(negedge clk);
    checkOutput({v.name, "_frame"}, bus.frame_o, 1);
    repeat (v.idx * PS + DC + 1) @(negedge clk);
    checkOutput({v.name, "_an"}, bus.an_o, v.exp_an);
    checkOutput({v.name, "_seg"}, bus.seg_o, v.exp_seg);
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  task automatic lzFrame(input logic [15:0] d, output int low_cnt [4], output logic [7:0] seg_t3,
                         output logic [7:0] seg_t11);
    bus.enable = 1'b0;
    @(negedge clk);
    bus.digits_i = d;
    bus.dp_i     = 4'b0000;
    bus.enable   = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) low_cnt[k] = 0;
    seg_t3 = 8'h00; seg_t11 = 8'h00;
    for (int c = 0; c < FRAME; c++) begin
      for (int k = 0; k < 4; k++) if (!bus.an_o[k]) low_cnt[k]++;
      if (c == 3)  seg_t3  = bus.seg_o;
      if (c == 11) seg_t11 = bus.seg_o;
      if (c < FRAME - 1) @(negedge clk);
    end
  endtask
`endif

  initial begin
    int cur;
`ifdef LEADING_ZERO_BLANK_EN
    int lc [4];
    logic [7:0] s3, s11;
`endif
    total_cnt = 0;
    bad_cnt   = 0;
    an_exp_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_1234   = '{8'h66, 8'hF2, 8'hDA, 8'h60};
    vecs[0] = '{"v1234_d0", 16'h1234, 4'b0000, 0, 4'b1110, 8'h66};
    vecs[1] = '{"v1234_d3", 16'h1234, 4'b0000, 3, 4'b0111, 8'h60};
    vecs[2] = '{"dp_d1",    16'h0000, 4'b0010, 1, 4'b1101, 8'hFD};
    vecs[3] = '{"dp_d0",    16'h0000, 4'b0010, 0, 4'b1110, 8'hFC};
    vecs[4] = '{"v9876_d1", 16'h9876, 4'b0000, 1, 4'b1101, 8'hE0};
    vecs[5] = '{"v9876_d2", 16'h9876, 4'b0000, 2, 4'b1011, 8'hFE};
    vecs[6] = '{"bad_d0",   16'h505A, 4'b0001, 0, 4'b1110, 8'h01};
    vecs[7] = '{"zero_d2",  16'h505A, 4'b0001, 2, 4'b1011, 8'hFC};
    vecs[8] = '{"bad_d3",   16'hF000, 4'b1000, 3, 4'b0111, 8'h01};

    rst_n        = 1'b0;
    bus.enable   = 1'b0;
    bus.digits_i = '0;
    bus.dp_i     = '0;
    @(negedge clk);
    checkOutput("rst_an", bus.an_o, 4'hF);
    checkOutput("rst_seg", bus.seg_o, 8'h00);
    checkOutput("rst_bcd", bus.bcd_o, 4'h0);
    checkOutput("rst_frame", bus.frame_o, 0);
    #1 rst_n = 1'b1;

    // Frame of 1234, one slot per digit, then the period to the next snapshot.
    @(negedge clk);
    bus.digits_i = 16'h1234;
    bus.enable   = 1'b1;
    @(negedge clk);
    checkOutput("frame_first", bus.frame_o, 1);
    cur = 0;
    for (int d = 0; d < ND; d++) begin
      repeat (d * PS + DC + 1 - cur) @(negedge clk);
      cur = d * PS + DC + 1;
      checkOutput("scan_an", bus.an_o, an_exp_tab[d]);
      checkOutput("scan_seg", bus.seg_o, seg_1234[d]);
    end
    repeat (FRAME - cur) @(negedge clk);
    checkOutput("frame_period", bus.frame_o, 1);

    // Mid-frame digit change stays invisible until the next snapshot.
    repeat (2 * PS - 1) @(negedge clk);
    bus.digits_i = 16'h9999;
    repeat (4) @(negedge clk);
    checkOutput("hold_d2_an", bus.an_o, 4'b1011);
    checkOutput("hold_d2_seg", bus.seg_o, 8'hDA);
    repeat (8) @(negedge clk);
    checkOutput("hold_d3_seg", bus.seg_o, 8'h60);
    repeat (5) @(negedge clk);
    checkOutput("new_frame", bus.frame_o, 1);
    repeat (3) @(negedge clk);
    checkOutput("nine_d0_seg", bus.seg_o, 8'hF6);
    repeat (24) @(negedge clk);
    checkOutput("nine_d3_an", bus.an_o, 4'b0111);
    checkOutput("nine_d3_seg", bus.seg_o, 8'hF6);

    // Enable drops in the middle of digit 2's drive phase.
    repeat (5 + 2 * PS + 4) @(negedge clk);
    checkOutput("pre_drop_an", bus.an_o, 4'b1011);
    bus.enable = 1'b0;
    @(negedge clk);
    checkOutput("drop_an", bus.an_o, 4'hF);
    checkOutput("drop_seg", bus.seg_o, 8'h00);
    repeat (2) @(negedge clk);
    bus.digits_i = 16'h1234;
    bus.enable   = 1'b1;
    @(negedge clk);
    checkOutput("restart_frame", bus.frame_o, 1);
    checkOutput("restart_bcd", bus.bcd_o, 4'h4);
    repeat (DC + 1) @(negedge clk);
    checkOutput("restart_an", bus.an_o, 4'b1110);
    checkOutput("restart_seg", bus.seg_o, 8'h66);

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

`ifdef LEADING_ZERO_BLANK_EN
    lzFrame(16'h0047, lc, s3, s11);
    checkOutput("lz47_d3_low", lc[3], 0);
    checkOutput("lz47_d2_low", lc[2], 0);
    checkOutput("lz47_d1_low", lc[1], PS - DC);
    checkOutput("lz47_d0_seg", s3, 8'hE0);
    checkOutput("lz47_d1_seg", s11, 8'h66);
    lzFrame(16'h0000, lc, s3, s11);
    checkOutput("lz0_hi_low", lc[3] + lc[2] + lc[1], 0);
    checkOutput("lz0_d0_low", lc[0], PS - DC);
    checkOutput("lz0_d0_seg", s3, 8'hFC);
`endif

    // Random digits, decimal points and enable glitches against the model.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) bus.digits_i = 16'($urandom);
      if ($urandom_range(0, 29) == 0) bus.dp_i = 4'($urandom);
      if (bus.enable) bus.enable = ($urandom_range(0, 149) != 0);
      else            bus.enable = ($urandom_range(0, 2) == 0);
    end
    bus.enable = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
